vector_serializer: RTL and testbench

Parametrised vector-to-stream serializer for the CNN datapath. It captures one packed vector of `array_size` words, each `data_size` bits wide, together with a per-lane select mask. It then emits the selected words one per cycle on a valid/ready output stream, in either lane order. It sits between the weight/activation buffers and the systolic-array input bus and replaces the earlier fixed 9×8 enable-driven shift-out buffer.

---
 rtl/vector_serializer.sv | 150 +++++++++++++++
 tb/tb_vector_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_serializer.sv
// Vector-to-stream serializer: captures a packed vector and a lane mask, then emits the
// selected lanes one per cycle on a valid/ready stream, lowest-first or highest-first.
module vector_serializer #(
    parameter int unsigned array_size = 9,
    parameter int unsigned data_size  = 8
) (
    input  logic                             r_clk,
    input  logic                             reset,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [array_size*data_size-1:0]  load_data,
    input  logic [array_size-1:0]            load_mask,
    input  logic                             msb_first,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [data_size-1:0]             out_data,
    output logic [$clog2(array_size)-1:0]    out_index,
    output logic                             out_last,
    output logic                             done
);

    localparam int unsigned IDX_W = $clog2(array_size);
    localparam logic [array_size-1:0] LaneOne = {{(array_size - 1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                          state_q, state_d;
    logic [array_size*data_size-1:0] data_q, data_d;
    logic [array_size-1:0]           mask_q, mask_d;
    logic                            dir_q, dir_d;
    logic                            out_valid_q, out_valid_d;
    logic [data_size-1:0]            out_data_q, out_data_d;
    logic [IDX_W-1:0]                out_index_q, out_index_d;
    logic                            out_last_q, out_last_d;
    logic                            done_q, done_d;

    logic                            out_hs;
    logic                            accept;
    logic [array_size-1:0]           rem_mask;
    logic [IDX_W-1:0]                lane;

    // Priority encode: lowest set bit when msb=0, highest when msb=1.
    function automatic logic [IDX_W-1:0] pick_lane(input logic [array_size-1:0] m,
                                                    input logic msb);
        logic [IDX_W-1:0]      idx;
        logic [array_size-1:0] sh;
        idx = '0;
        for (int i = 0; i < int'(array_size); i++) begin
            if (msb) begin
                sh = m >> i;
                if (sh[0]) idx = IDX_W'(i);
            end else begin
                sh = m >> (int'(array_size) - 1 - i);
                if (sh[0]) idx = IDX_W'(int'(array_size) - 1 - i);
            end
        end
        return idx;
    endfunction

    function automatic logic [data_size-1:0] lane_word(
        input logic [array_size*data_size-1:0] d,
        input logic [IDX_W-1:0]                idx
    );
        return data_size'(d >> (idx * data_size));
    endfunction

    function automatic logic is_single(input logic [array_size-1:0] m);
        return (m != '0) && ((m & (m - LaneOne)) == '0);
    endfunction

    assign out_hs     = out_valid_q && out_ready;
    assign load_ready = (state_q == StIdle) || (out_hs && out_last_q);
    assign accept     = load_valid && load_ready;
    assign rem_mask   = mask_q & ~(LaneOne << out_index_q);

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mask_d      = mask_q;
        dir_d       = dir_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        lane        = '0;
        done_d      = (out_hs && out_last_q) || (accept && (load_mask == '0));

        if (accept) begin
            data_d = load_data;
            dir_d  = msb_first;
            mask_d = load_mask;
            if (load_mask != '0) begin
                lane        = pick_lane(load_mask, msb_first);
                state_d     = StShift;
                out_valid_d = 1'b1;
                out_data_d  = lane_word(load_data, lane);
                out_index_d = lane;
                out_last_d  = is_single(load_mask);
            end else begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end else if (out_hs) begin
            if (out_last_q) begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                mask_d      = '0;
            end else begin
                lane        = pick_lane(rem_mask, dir_q);
                mask_d      = rem_mask;
                out_data_d  = lane_word(data_q, lane);
                out_index_d = lane;
                out_last_d  = is_single(rem_mask);
            end
        end
    end

    always_ff @(posedge r_clk) begin
        if (reset) begin
            state_q     <= StIdle;
            data_q      <= '0;
            mask_q      <= '0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vector_serializer.sv
// Scoreboard bench for vector_serializer: expected words are queued at load acceptance and
// checked as the stream hands them off; done, load_ready, hold and reset behaviour checked per cycle.
module tb_vector_serializer;

    localparam int unsigned AS = 9;
    localparam int unsigned DS = 8;
    localparam int unsigned IW = $clog2(AS);

    logic              r_clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic              load_ready;
    logic [AS*DS-1:0]  load_data;
    logic [AS-1:0]     load_mask;
    logic              msb_first;
    logic              out_valid;
    logic              out_ready;
    logic [DS-1:0]     out_data;
    logic [IW-1:0]     out_index;
    logic              out_last;
    logic              done;

    vector_serializer #(.array_size(AS), .data_size(DS)) dut (
        .r_clk      (r_clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_mask  (load_mask),
        .msb_first  (msb_first),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .done       (done)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic [DS-1:0] d;
        logic [IW-1:0] i;
        logic          l;
    } exp_t;

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_miss = 0;
    int            pops = 0;
    logic          pend_done = 1'b0;
    logic          post_rst = 1'b0;
    logic          hold_chk = 1'b0;
    logic [31:0]   held = '0;
    logic          accepted = 1'b0;
    logic          bp_mode = 1'b0;
    int            bp_cnt = 0;

    localparam logic [AS*DS-1:0] D0 = 72'h010203040506070809;
    localparam logic [AS*DS-1:0] DA = 72'hA8A7A6A5A4A3A2A1A0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference order: walk the mask in the requested direction, tag the final lane as last.
    task automatic push_vector(input logic [AS*DS-1:0] d, input logic [AS-1:0] m,
                               input logic msb);
        exp_t e;
        int   n = 0;
        for (int k = 0; k < int'(AS); k++) begin
            int lane;
            lane = msb ? (int'(AS) - 1 - k) : k;
            if (m[lane]) begin
                e.d = d[lane*DS +: DS];
                e.i = IW'(lane);
                e.l = 1'b0;
                sb.push_back(e);
                n++;
            end
        end
        if (n > 0) sb[sb.size()-1].l = 1'b1;
    endtask

    always @(negedge r_clk) begin
        logic hs, exp_rdy, new_done;
        exp_t e;
        if (reset) begin
            sb.delete();
            pend_done = 1'b0;
            post_rst  = 1'b1;
            hold_chk  = 1'b0;
            accepted  = 1'b0;
        end else begin
            check_eq("done", 32'(done), 32'(pend_done));
            if (post_rst) begin
                check_eq("rst_data", 32'(out_data), 32'h0);
                check_eq("rst_index", 32'(out_index), 32'h0);
                check_eq("rst_last", 32'(out_last), 32'h0);
                post_rst = 1'b0;
            end
            check_eq("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (hold_chk && out_valid)
                check_eq("hold", {19'b0, out_data, out_index, out_last}, held);
            hs      = out_valid && out_ready;
            exp_rdy = (sb.size() == 0) || (hs && sb[0].l);
            check_eq("load_ready", 32'(load_ready), 32'(exp_rdy));
            new_done = 1'b0;
            if (hs) begin
                if (sb.size() == 0) begin
                    check_eq("extra_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check_eq("data", 32'(out_data), 32'(e.d));
                    check_eq("index", 32'(out_index), 32'(e.i));
                    check_eq("last", 32'(out_last), 32'(e.l));
                    if (e.l) new_done = 1'b1;
                    pops++;
                end
            end
            hold_chk = out_valid && !out_ready;
            held     = {19'b0, out_data, out_index, out_last};
            accepted = load_valid && exp_rdy;
            if (accepted) begin
                push_vector(load_data, load_mask, msb_first);
                if (load_mask == '0) new_done = 1'b1;
            end
            pend_done = new_done;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge r_clk);
            #1;
            if (bp_mode) begin
                out_ready = (bp_cnt % 3 == 0);
                bp_cnt++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic do_load(input logic [AS*DS-1:0] d, input logic [AS-1:0] m, input logic msb);
        bit ok = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        load_mask  = m;
        msb_first  = msb;
        for (int c = 0; c < 200; c++) begin
            @(posedge r_clk);
            if (accepted) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("load_timeout", 32'h0, 32'h1);
        #1;
        load_valid = 1'b0;
        load_data  = '1;
        load_mask  = '1;
        msb_first  = ~msb;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge r_clk);
            if (sb.size() == 0 && !pend_done && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("idle_timeout", 32'h0, 32'h1);
        @(posedge r_clk);
        #1;
    endtask

    initial begin
        int base;
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = D0;
        load_mask  = '1;
        msb_first  = 1'b0;
        repeat (3) @(posedge r_clk);
        #1;
        reset      = 1'b0;
        load_valid = 1'b0;
        repeat (2) @(posedge r_clk);
        #1;

        do_load(D0, 9'h1FF, 1'b0);
        wait_idle();

        do_load(D0, 9'b100010010, 1'b1);
        wait_idle();

        bp_mode = 1'b1;
        do_load(D0, 9'h1FF, 1'b0);
        wait_idle();
        bp_mode = 1'b0;
        @(posedge r_clk);
        #1;

        do_load(D0, 9'h1FF, 1'b0);
        do_load(DA, 9'h1FF, 1'b0);
        wait_idle();

        do_load(D0, 9'h000, 1'b0);
        wait_idle();

        do_load(D0, 9'h1FF, 1'b0);
        base = pops;
        for (int c = 0; c < 50 && pops < base + 3; c++) @(posedge r_clk);
        check_eq("pops_before_reset", 32'(pops - base), 32'd3);
        #1;
        reset = 1'b1;
        @(posedge r_clk);
        #1;
        reset = 1'b0;
        @(posedge r_clk);
        #1;
        do_load(D0, 9'b000100100, 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
